// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the PIO input block: register word addresses and edge-type encodings.
package soc_system_pio_pkg;
  localparam int ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/soc_system_pio_in_if.sv
// Avalon-MM slave bus of the PIO input block, including its level interrupt.
interface soc_system_pio_in_if;
  import soc_system_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              irq;

  modport master (output address, chipselect, read_n, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, read_n, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/soc_system_pio_in_sync.sv
// Multi-flop input synchronizer plus edge detector, gated off while the chain primes after reset.
module soc_system_pio_in_sync
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_sync,
  output logic [WIDTH-1:0] edge_det
);
  localparam int            PW         = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev;
  logic [WIDTH-1:0]                  raw_edge;
  logic [PW-1:0]                     prime_cnt;
  logic                              primed;

  assign data_sync = sync_q[SYNC_STAGES-1];
  assign primed    = (prime_cnt == PRIME_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      prev      <= '0;
      prime_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev   <= data_sync;
      if (!primed) prime_cnt <= prime_cnt + PW'(1);
    end
  end

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign raw_edge = data_sync & ~prev;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign raw_edge = ~data_sync & prev;
    end else begin : g_any
      assign raw_edge = data_sync ^ prev;
    end
  endgenerate

  // Until the chain has flushed its reset zeros, a transition is an artefact, not an edge.
  assign edge_det = primed ? raw_edge : '0;
endmodule

// File: rtl/soc_system_pio_in.sv
// PIO input port: synchronized data, sticky edge capture with write-1-clear, optional masked irq.
// Optional feature macro: SOC_SYSTEM_PIO_IN_IRQ_EN (irq mask register and interrupt logic).
module soc_system_pio_in
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                 clk,
  input  logic                 reset,
  soc_system_pio_in_if.slave   bus,
  input  logic [WIDTH-1:0]     in_port
);
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_word;
  logic [31:0]      readdata_q;
  logic             irq_q;
  logic             wr_en;
  logic             rd_en;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign rd_en        = bus.chipselect & ~bus.read_n;
  assign unused_wdata = ^bus.writedata;

  soc_system_pio_in_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .data_sync (data_sync),
    .edge_det  (edge_det)
  );

  assign clr = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  // OR-ing the edge in after the clear lets a simultaneous set win.
  always_ff @(posedge clk) begin
    if (reset) capture <= '0;
    else       capture <= (capture & ~clr) | edge_det;
  end

`ifdef SOC_SYSTEM_PIO_IN_IRQ_EN
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask  <= '0;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && bus.address == ADDR_MASK) mask <= bus.writedata[WIDTH-1:0];
      irq_q <= |(capture & mask);
    end
  end
`else
  assign irq_q = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (bus.address)
      ADDR_DATA: rd_word[WIDTH-1:0] = data_sync;
`ifdef SOC_SYSTEM_PIO_IN_IRQ_EN
      ADDR_MASK: rd_word[WIDTH-1:0] = mask;
`endif
      ADDR_EDGE: rd_word[WIDTH-1:0] = capture;
      default:   rd_word = '0;
    endcase
  end

  // Sampling register state before this edge's writes gives pre-write read data.
  always_ff @(posedge clk) begin
    if (reset)      readdata_q <= '0;
    else if (rd_en) readdata_q <= rd_word;
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;
endmodule

// File: doc/soc_system_pio_in.md
SOC_SYSTEM_PIO_IN -- requirements
Module: soc_system_pio_in

Interface
REQ-001 Parameter WIDTH, default 10: number of input bits on in_port, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops per bit, 2..4.
REQ-003 Parameter EDGE_TYPE, default 0: edge that sets a capture bit; 0 = rising, 1 = falling, 2 = any.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  2  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 read_n  in  1  active-low read strobe.
REQ-009 write_n  in  1  active-low write strobe.
REQ-010 writedata  in  32  write data.
REQ-011 in_port  in  WIDTH  asynchronous external inputs.
REQ-012 readdata  out  32  registered read data.
REQ-013 irq  out  1  level interrupt, registered.

Function
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep synchronizer; the last stage is "data_sync".
REQ-015 A prev register SHALL hold data_sync delayed by one cycle. An edge on bit i SHALL be declared per EDGE_TYPE from prev[i] and data_sync[i].
REQ-016 A prime counter SHALL suppress edge detection for SYNC_STAGES+1 cycles after reset deassertion. No capture bit SHALL set while it counts.
REQ-017 Register map, address 0: data_sync, read-only; writes are ignored.
REQ-018 Register map, address 1: reserved; reads return 0 and writes are ignored.
REQ-019 Register map, address 2: irq mask, read/write, bits [WIDTH-1:0].
REQ-020 Register map, address 3: edge capture; a read returns it, and a write clears each bit where writedata is 1.
REQ-021 A write SHALL occur when chipselect=1 and write_n=0, taking effect at the next clock edge.
REQ-022 Read latency SHALL be exactly 1 cycle: readdata is registered on cycles with chipselect=1 and read_n=0 and holds its value otherwise.
REQ-023 Read data bits [31:WIDTH] SHALL always be 0.
REQ-024 A capture bit SHALL set on a detected edge and hold until cleared.
REQ-025 If an edge and a write-1-clear hit the same bit in the same cycle, the set SHALL win.
REQ-026 A read of address 3 SHALL NOT clear any capture bit.
REQ-027 irq SHALL be registered as OR(capture & mask), asserting 1 cycle after the capture or mask update.
REQ-028 If read and write are both asserted in one cycle, readdata SHALL return the pre-write value.

Reset
REQ-029 While reset=1, every flop SHALL clear: synchronizer, prev, prime counter, mask, capture, readdata=0 and irq=0.
REQ-030 Reset asserted mid-operation SHALL discard pending edges and clear the capture register within the same cycle. Priming restarts on release.

Configuration
REQ-031 Macro SOC_SYSTEM_PIO_IN_IRQ_EN defined: the mask register and irq logic are present, per REQ-019 and REQ-027.
REQ-032 Macro SOC_SYSTEM_PIO_IN_IRQ_EN undefined: the irq port remains but is tied 0, address 2 reads 0 and ignores writes, and edge capture still functions.

Structure
REQ-033 Package soc_system_pio_pkg SHALL hold the register address constants (DATA=0, MASK=2, EDGE=3) and the EDGE_TYPE encodings.
REQ-034 The per-bit synchronizer and edge detector SHALL be a sub-module soc_system_pio_in_sync, instantiated once with width WIDTH.

Verification
REQ-035 After reset, drive in_port=10'h3FF, wait 5 cycles, then read address 0 -> readdata=32'h3FF. Then read address 3 -> readdata=0, because priming suppressed the edge.
REQ-036 With EDGE_TYPE=0, toggle in_port[3] 0->1 -> edge capture bit 3 set SYNC_STAGES+1 cycles later. Then write 32'h8 to address 3 -> the capture register reads 0.
REQ-037 Write mask 32'h8, then create a rising edge on bit 3 -> irq=1 one cycle after the capture bit sets. Then write 32'h0 to the mask -> irq=0 one cycle later.
REQ-038 Time a write-1-clear of bit 5 to land in the same cycle that a bit-5 edge is detected -> bit 5 remains 1.
REQ-039 Set capture bits 32'h3, then assert reset for 1 cycle -> capture=0, mask=0, irq=0 and readdata=0. A subsequent read of address 3 -> 0.
REQ-040 Build without SOC_SYSTEM_PIO_IN_IRQ_EN, write 32'hFFFFFFFF to address 2 and create an edge -> irq=0, address 2 reads 0, and address 3 shows the edge.
